// File: rtl/hw_assign_seq.sv
// hw_assign_seq: drives one operand pair through every sel value of the
// hw_assign mux. Each sel value is held for DWELL cycles. The mux output is
// sampled at the end of each step. The samples are returned as one packed
// result word over a valid/ready handshake.
module hw_assign_seq #(
    parameter int unsigned DW    = 3,
    parameter int unsigned SELW  = 2,
    parameter int unsigned DWELL = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DW-1:0]            in_din0,
    input  logic [DW-1:0]            in_din1,
    output logic [DW-1:0]            din0,
    output logic [DW-1:0]            din1,
    output logic [SELW-1:0]          sel,
    input  logic [DW-1:0]            mux_dout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [(DW<<SELW)-1:0]    res_data,
    output logic                     busy
);

    localparam int unsigned STEPS = 1 << SELW;
    localparam int unsigned CW    = $clog2(DWELL + 1);
    localparam int unsigned RW    = STEPS * DW;

    localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
    localparam logic [SELW-1:0] SEL_LAST = SELW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_REPORT = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DW-1:0]     r_din0;
    logic [DW-1:0]     r_din1;
    logic [SELW-1:0]   r_sel;
    logic [CW-1:0]     r_cnt;
    logic [RW-1:0]     r_slot;
    logic [RW-1:0]     r_res_data;
    logic              r_res_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic [DW-1:0]     w_din0_nxt;
    logic [DW-1:0]     w_din1_nxt;
    logic [SELW-1:0]   w_sel_nxt;
    logic [CW-1:0]     w_cnt_nxt;
    logic [RW-1:0]     w_slot_nxt;
    logic [RW-1:0]     w_res_data_nxt;
    logic              w_res_valid_nxt;
    logic              w_in_ready_nxt;
    logic              w_busy_nxt;

    logic              w_accept;
    logic              w_step_end;
    logic              w_run_done;
    logic              w_res_done;

    // Handshake and step-boundary qualifiers
    assign w_accept   = (r_state == S_IDLE) && in_valid && r_in_ready;
    assign w_step_end = (r_state == S_RUN) && (r_cnt == CNT_LAST);
    assign w_run_done = w_step_end && (r_sel == SEL_LAST);
    assign w_res_done = (r_state == S_REPORT) && r_res_valid && res_ready;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_run_done) begin
                    w_state_nxt = S_REPORT;
                end
            end
            S_REPORT: begin
                if (w_res_done) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Next values of the registered outputs; everything holds unless stepped
    always_comb begin
        w_din0_nxt      = r_din0;
        w_din1_nxt      = r_din1;
        w_sel_nxt       = r_sel;
        w_cnt_nxt       = r_cnt;
        w_slot_nxt      = r_slot;
        w_res_data_nxt  = r_res_data;
        w_res_valid_nxt = r_res_valid;
        w_in_ready_nxt  = r_in_ready;
        w_busy_nxt      = r_busy;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_din0_nxt     = in_din0;
                    w_din1_nxt     = in_din1;
                    w_sel_nxt      = '0;
                    w_cnt_nxt      = '0;
                    w_in_ready_nxt = 1'b0;
                    w_busy_nxt     = 1'b1;
                end
            end
            S_RUN: begin
                w_cnt_nxt = r_cnt + CW'(1);
                if (w_step_end) begin
                    for (int unsigned i = 0; i < STEPS; i++) begin
                        if (r_sel == SELW'(i)) begin
                            w_slot_nxt[i*DW +: DW] = mux_dout;
                        end
                    end
                    w_cnt_nxt = '0;
                    if (w_run_done) begin
                        // Publish the full word only now so res_data keeps the
                        // previous result for the whole run.
                        w_res_data_nxt  = w_slot_nxt;
                        w_res_valid_nxt = 1'b1;
                    end else begin
                        w_sel_nxt = r_sel + SELW'(1);
                    end
                end
            end
            S_REPORT: begin
                if (w_res_done) begin
                    w_res_valid_nxt = 1'b0;
                    w_in_ready_nxt  = 1'b1;
                    w_busy_nxt      = 1'b0;
                end
            end
            default: begin
                w_res_valid_nxt = 1'b0;
                w_in_ready_nxt  = 1'b1;
                w_busy_nxt      = 1'b0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_din0      <= '0;
            r_din1      <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_slot      <= '0;
            r_res_data  <= '0;
            r_res_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_din0      <= w_din0_nxt;
            r_din1      <= w_din1_nxt;
            r_sel       <= w_sel_nxt;
            r_cnt       <= w_cnt_nxt;
            r_slot      <= w_slot_nxt;
            r_res_data  <= w_res_data_nxt;
            r_res_valid <= w_res_valid_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign din0      = r_din0;
    assign din1      = r_din1;
    assign sel       = r_sel;
    assign res_data  = r_res_data;
    assign res_valid = r_res_valid;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;

endmodule

// File: tb/tb_hw_assign_seq.sv
// Testbench for hw_assign_seq with a behavioural hw_assign mux stub.
// Two builds are instantiated: DWELL=10 and DWELL=1.
module tb_hw_assign_seq;

    logic        clk;
    logic        rst_n;

    // DWELL=10 instance
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_din0;
    logic [2:0]  in_din1;
    logic [2:0]  din0;
    logic [2:0]  din1;
    logic [1:0]  sel;
    logic [2:0]  mux_dout;
    logic        res_valid;
    logic        res_ready;
    logic [11:0] res_data;
    logic        busy;

    // DWELL=1 instance
    logic        q_in_valid;
    logic        q_in_ready;
    logic [2:0]  q_in_din0;
    logic [2:0]  q_in_din1;
    logic [2:0]  q_din0;
    logic [2:0]  q_din1;
    logic [1:0]  q_sel;
    logic [2:0]  q_mux_dout;
    logic        q_res_valid;
    logic        q_res_ready;
    logic [11:0] q_res_data;
    logic        q_busy;

    int errors;
    int checks;
    logic [11:0] exp_q[$];

    // hw_assign stub: sel0 din0, sel1 din1, sel2 and, sel3 or
    function automatic logic [2:0] hw_assign_model(input logic [1:0] s,
                                                   input logic [2:0] a,
                                                   input logic [2:0] b);
        case (s)
            2'd0:    return a;
            2'd1:    return b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    // Expected packed word, slot i = mux output with sel==i
    function automatic logic [11:0] exp_word(input logic [2:0] a, input logic [2:0] b);
        return {a | b, a & b, b, a};
    endfunction

    assign mux_dout   = hw_assign_model(sel, din0, din1);
    assign q_mux_dout = hw_assign_model(q_sel, q_din0, q_din1);

    hw_assign_seq #(.DW(3), .SELW(2), .DWELL(10)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din0   (in_din0),
        .in_din1   (in_din1),
        .din0      (din0),
        .din1      (din1),
        .sel       (sel),
        .mux_dout  (mux_dout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    hw_assign_seq #(.DW(3), .SELW(2), .DWELL(1)) u_dut_d1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (q_in_valid),
        .in_ready  (q_in_ready),
        .in_din0   (q_in_din0),
        .in_din1   (q_in_din1),
        .din0      (q_din0),
        .din1      (q_din1),
        .sel       (q_sel),
        .mux_dout  (q_mux_dout),
        .res_valid (q_res_valid),
        .res_ready (q_res_ready),
        .res_data  (q_res_data),
        .busy      (q_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a pair at the negedge, let the next posedge accept it.
    // Optionally keep in_valid high afterwards and record the expected word.
    task automatic start_pair(input logic [2:0] a, input logic [2:0] b,
                              input bit hold, input bit push);
        @(negedge clk);
        in_valid = 1'b1;
        in_din0  = a;
        in_din1  = b;
        @(posedge clk);
        if (push) exp_q.push_back(exp_word(a, b));
        #1;
        in_valid = hold;
    endtask

    // Wait for res_valid; latency counts the accept cycle itself as 1
    task automatic wait_res(input int limit, output int lat);
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < limit) begin
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_valid_busy: got %b/%b want 0/0", res_valid, busy);
        end
        checks++;
        if ({din0, din1, sel} !== 8'h00 || res_data !== 12'h000) begin
            errors++; $display("FAIL reset_regs: got din0=%0d din1=%0d sel=%0d res=%o want all 0",
                               din0, din1, sel, res_data);
        end
    endtask

    task automatic test_basic;
        int lat;
        logic [11:0] e;
        res_ready = 1'b1;
        start_pair(3'd2, 3'd1, 1'b0, 1'b1);
        wait_res(200, lat);
        checks++;
        if (res_valid !== 1'b1 || lat != 41) begin
            errors++; $display("FAIL basic_latency: got valid=%b lat=%0d want 1/41", res_valid, lat);
        end
        if (exp_q.size() == 0) begin errors++; checks++; $display("FAIL basic_sb: got empty queue want 1 entry"); end
        else begin
            e = exp_q.pop_front();
            checks++;
            if (res_data !== e || res_data !== 12'o3012) begin
                errors++; $display("FAIL basic_data: got %o want %o", res_data, 12'o3012);
            end
        end
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_idle: got valid=%b ready=%b busy=%b want 0/1/0",
                               res_valid, in_ready, busy);
        end
    endtask

    task automatic test_stall;
        int lat;
        int bad;
        logic [11:0] e;
        res_ready = 1'b0;
        start_pair(3'd3, 3'd6, 1'b0, 1'b1);
        wait_res(200, lat);
        checks++;
        if (res_valid !== 1'b1 || lat != 41) begin
            errors++; $display("FAIL stall_latency: got valid=%b lat=%0d want 1/41", res_valid, lat);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        // A pair offered during REPORT must be ignored
        in_valid = 1'b1;
        in_din0  = 3'd0;
        in_din1  = 3'd0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid !== 1'b1 || res_data !== e || in_ready !== 1'b0 || din0 !== 3'd3) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || e !== 12'o7263) begin
            errors++; $display("FAIL stall_hold: got %0d unstable cycles data=%o want 0 and %o",
                               bad, res_data, 12'o7263);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || din0 !== 3'd3) begin
            errors++; $display("FAIL stall_release: got ready=%b valid=%b busy=%b din0=%0d want 1/0/0/3",
                               in_ready, res_valid, busy, din0);
        end
    endtask

    task automatic test_ignore;
        int lat;
        logic [11:0] e;
        res_ready = 1'b1;
        start_pair(3'd2, 3'd1, 1'b1, 1'b1);
        in_din0 = 3'd5;
        in_din1 = 3'd5;
        repeat (15) @(negedge clk);
        checks++;
        if (din0 !== 3'd2 || din1 !== 3'd1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL ignore_run: got din=%0d/%0d ready=%b want 2/1/0", din0, din1, in_ready);
        end
        lat = 0;
        while (!res_valid && lat < 200) begin lat++; @(negedge clk); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        checks++;
        if (res_valid !== 1'b1 || res_data !== e) begin
            errors++; $display("FAIL ignore_first: got valid=%b data=%o want 1/%o", res_valid, res_data, e);
        end
        @(negedge clk);
        exp_q.push_back(exp_word(3'd5, 3'd5));
        checks++;
        if (in_ready !== 1'b1 || din0 !== 3'd2) begin
            errors++; $display("FAIL ignore_idle: got ready=%b din0=%0d want 1/2", in_ready, din0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (din0 !== 3'd5 || in_ready !== 1'b0 || res_data !== 12'o3012) begin
            errors++; $display("FAIL ignore_second_accept: got din0=%0d ready=%b res=%o want 5/0/3012",
                               din0, in_ready, res_data);
        end
        lat = 0;
        while (!res_valid && lat < 200) begin lat++; @(negedge clk); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        checks++;
        if (res_valid !== 1'b1 || res_data !== e || e !== 12'o5555) begin
            errors++; $display("FAIL ignore_second: got valid=%b data=%o want 1/5555", res_valid, res_data);
        end
        @(negedge clk);
    endtask

    task automatic test_dwell1;
        int lat;
        int kk;
        int bad;
        logic [11:0] e;
        q_res_ready = 1'b1;
        @(negedge clk);
        q_in_valid = 1'b1;
        q_in_din0  = 3'd7;
        q_in_din1  = 3'd0;
        @(posedge clk);
        exp_q.push_back(exp_word(3'd7, 3'd0));
        #1;
        q_in_valid = 1'b0;
        lat = 1;
        kk  = 0;
        bad = 0;
        @(negedge clk);
        while (!q_res_valid && lat < 50) begin
            if (q_sel !== 2'(kk)) bad++;
            kk++;
            lat++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0 || kk != 4) begin
            errors++; $display("FAIL d1_sel_sweep: got %0d wrong of %0d steps want 0 of 4", bad, kk);
        end
        checks++;
        if (q_res_valid !== 1'b1 || lat != 5) begin
            errors++; $display("FAIL d1_latency: got valid=%b lat=%0d want 1/5", q_res_valid, lat);
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        checks++;
        if (q_res_data !== e || e !== 12'o7007) begin
            errors++; $display("FAIL d1_data: got %o want %o", q_res_data, 12'o7007);
        end
        @(negedge clk);
        checks++;
        if (q_in_ready !== 1'b1 || q_res_valid !== 1'b0) begin
            errors++; $display("FAIL d1_idle: got ready=%b valid=%b want 1/0", q_in_ready, q_res_valid);
        end
    endtask

    task automatic test_reset_mid;
        int seen;
        res_ready = 1'b1;
        start_pair(3'd6, 3'd3, 1'b0, 1'b0);
        @(negedge clk);
        repeat (24) @(negedge clk);
        checks++;
        if (sel !== 2'd2 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pos: got sel=%0d busy=%b want 2/1", sel, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (sel !== 2'd0 || din0 !== 3'd0 || res_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_state: got sel=%0d din0=%0d valid=%b ready=%b busy=%b want 0/0/0/1/0",
                               sel, din0, res_valid, in_ready, busy);
        end
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL rstmid_no_result: got %0d valid cycles want 0", seen);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [11:0] e;
        res_ready = 1'b1;
        start_pair(3'd1, 3'd2, 1'b1, 1'b1);
        in_din0 = 3'd4;
        in_din1 = 3'd4;
        wait_res(200, lat);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        checks++;
        if (res_valid !== 1'b1 || lat != 41 || res_data !== e || e !== 12'o3021) begin
            errors++; $display("FAIL b2b_first: got valid=%b lat=%0d data=%o want 1/41/3021",
                               res_valid, lat, res_data);
        end
        @(negedge clk);
        exp_q.push_back(exp_word(3'd4, 3'd4));
        checks++;
        if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_report_exit: got ready=%b valid=%b want 1/0", in_ready, res_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (din0 !== 3'd4 || busy !== 1'b1 || sel !== 2'd0) begin
            errors++; $display("FAIL b2b_second_accept: got din0=%0d busy=%b sel=%0d want 4/1/0", din0, busy, sel);
        end
        lat = 0;
        while (!res_valid && lat < 200) begin lat++; @(negedge clk); end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 12'hfff;
        checks++;
        if (res_valid !== 1'b1 || lat != 40 || res_data !== e || e !== 12'o4444) begin
            errors++; $display("FAIL b2b_second: got valid=%b wait=%0d data=%o want 1/40/4444",
                               res_valid, lat, res_data);
        end
        @(negedge clk);
    endtask

    initial begin
        errors      = 0;
        checks      = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_din0     = 3'd0;
        in_din1     = 3'd0;
        res_ready   = 1'b0;
        q_in_valid  = 1'b0;
        q_in_din0   = 3'd0;
        q_in_din1   = 3'd0;
        q_res_ready = 1'b0;

        test_reset();
        test_basic();
        test_stall();
        test_ignore();
        test_dwell1();
        test_reset_mid();
        test_back_to_back();

        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_drain: got %0d leftover entries want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on the whole run in case the DUT never responds
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
